// File: rtl/if_id_hazard_ctrl.sv
// PC / IF-ID sequencer: load-use stalls, taken-branch flushes, instruction-memory wait.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module if_id_hazard_ctrl #(
   parameter int FLUSH_CYCLES      = 1,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int REG_ADDR_W        = 5
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  take_branch,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  imem_ready,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  stall_active
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]           stall_cycles,
   output logic [15:0]           flush_cycles
`endif
);

   localparam int MAX_C = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
   localparam int CNT_W = $clog2(MAX_C + 1);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LS_INIT    = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic             FLUSH_MULTI = (FLUSH_CYCLES > 1);
   localparam logic             LS_MULTI    = (LOAD_STALL_CYCLES > 1);

   typedef enum logic [1:0] {RUN, FLUSH, LOAD_STALL, IMEM_WAIT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             luh;

   // Register 0 is hard-wired, so a load targeting it never creates a dependency.
   assign luh = ex_is_load && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_active = (state != RUN);
      state_nxt    = state;
      cnt_nxt      = cnt;
      if (!nreset) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         stall_active = 1'b0;
         state_nxt    = RUN;
         cnt_nxt      = '0;
      end else if (take_branch) begin
         pc_en        = 1'b1;
         if_id_en     = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_nxt    = FLUSH_MULTI ? FLUSH : RUN;
         cnt_nxt      = FLUSH_MULTI ? FLUSH_INIT : '0;
      end else begin
         case (state)
            RUN, IMEM_WAIT: begin
               if (luh) begin
                  id_ex_bubble = 1'b1;
                  state_nxt    = LS_MULTI ? LOAD_STALL : RUN;
                  cnt_nxt      = LS_MULTI ? LS_INIT : '0;
               end else if (!imem_ready) begin
                  // Flush wins over enable inside IF/ID; enable kept high alongside it.
                  if_id_en    = 1'b1;
                  if_id_flush = 1'b1;
                  state_nxt   = IMEM_WAIT;
               end else begin
                  pc_en     = 1'b1;
                  if_id_en  = 1'b1;
                  state_nxt = RUN;
               end
            end
            FLUSH: begin
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            LOAD_STALL: begin
               id_ex_bubble = 1'b1;
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clock) begin
      if (!nreset) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (!pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
         if (if_id_flush && flush_cycles != 16'hFFFF) flush_cycles <= flush_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench: two instances (FLUSH=2/LS=1 and FLUSH=2/LS=3) share one stimulus stream.
// Output vectors are {pc_en, if_id_en, if_id_flush, id_ex_bubble, stall_active}.
module tb_if_id_hazard_ctrl;

   logic       clock = 1'b0;
   logic       nreset;
   logic       take_branch, ex_is_load, id_uses_rs1, id_uses_rs2, imem_ready;
   logic [4:0] ex_rd, id_rs1, id_rs2;

   logic pc_a, en_a, fl_a, bb_a, st_a;
   logic pc_b, en_b, fl_b, bb_b, st_b;
   logic [4:0] oa, ob;
   assign oa = {pc_a, en_a, fl_a, bb_a, st_a};
   assign ob = {pc_b, en_b, fl_b, bb_b, st_b};

   int n_chk  = 0;
   int n_fail = 0;

`ifdef HAZARD_STATS_EN
   logic [15:0] sc_a, fc_a, sc_b, fc_b;
   logic [15:0] sc_base;
`endif

   always #5 clock = ~clock;

   if_id_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) u_a (
      .clock(clock), .nreset(nreset), .take_branch(take_branch), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .imem_ready(imem_ready), .pc_en(pc_a), .if_id_en(en_a),
      .if_id_flush(fl_a), .id_ex_bubble(bb_a), .stall_active(st_a)
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc_a), .flush_cycles(fc_a)
`endif
   );

   if_id_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(3), .REG_ADDR_W(5)) u_b (
      .clock(clock), .nreset(nreset), .take_branch(take_branch), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .imem_ready(imem_ready), .pc_en(pc_b), .if_id_en(en_b),
      .if_id_flush(fl_b), .id_ex_bubble(bb_b), .stall_active(st_b)
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc_b), .flush_cycles(fc_b)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic br, input logic ld, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic rdy);
      take_branch = br;  ex_is_load = ld;  ex_rd = rd;
      id_rs1 = r1;  id_uses_rs1 = u1;  id_rs2 = r2;  id_uses_rs2 = u2;  imem_ready = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   // Inputs were set just after the previous edge; check mid-cycle, then advance.
   task automatic cyc(input string tag, input logic [4:0] ea, input logic [4:0] eb);
      #4;
      chk({tag, "_a"}, {11'd0, oa}, {11'd0, ea});
      chk({tag, "_b"}, {11'd0, ob}, {11'd0, eb});
      @(posedge clock);
      #1;
   endtask

   initial begin
      nreset = 1'b0;
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc("reset", 5'b00110, 5'b00110);

      nreset = 1'b1;
      idle();
      cyc("post_reset", 5'b11000, 5'b11000);

      // load-use via rs2
      drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      cyc("luh_rs2", 5'b00010, 5'b00010);
      idle();
      cyc("luh_after1", 5'b11000, 5'b00011);
      cyc("luh_after2", 5'b11000, 5'b00011);
      cyc("luh_after3", 5'b11000, 5'b11000);

      // ex_rd=0 and unused source never stall
      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
      cyc("luh_rd0", 5'b11000, 5'b11000);
      drive(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b1);
      cyc("luh_unused", 5'b11000, 5'b11000);

      // taken branch, FLUSH_CYCLES=2
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("br_c1", 5'b11110, 5'b11110);
      idle();
      cyc("br_c2", 5'b11111, 5'b11111);
      cyc("br_run", 5'b11000, 5'b11000);

      // branch beats load-use on rs1
      drive(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1);
      cyc("br_luh_c1", 5'b11110, 5'b11110);
      idle();
      cyc("br_luh_c2", 5'b11111, 5'b11111);
      cyc("br_luh_run", 5'b11000, 5'b11000);

      // instruction memory wait, 4 cycles
`ifdef HAZARD_STATS_EN
      sc_base = sc_a;
`endif
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("imem_w1", 5'b01100, 5'b01100);
      for (int i = 0; i < 3; i++) cyc("imem_wn", 5'b01101, 5'b01101);
      idle();
      cyc("imem_ready", 5'b11001, 5'b11001);
`ifdef HAZARD_STATS_EN
      chk("stall_cycles", sc_a - sc_base, 16'd4);
`endif
      cyc("imem_run", 5'b11000, 5'b11000);

      // load-use during IMEM_WAIT acts as in RUN
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("iw_enter", 5'b01100, 5'b01100);
      drive(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
      cyc("iw_luh", 5'b00011, 5'b00011);
      idle();
      cyc("iw_luh_n1", 5'b11000, 5'b00011);
      cyc("iw_luh_n2", 5'b11000, 5'b00011);
      cyc("iw_luh_n3", 5'b11000, 5'b11000);

      // branch in 2nd load-stall cycle aborts the stall (instance b)
      drive(1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
      cyc("ls_br_c1", 5'b00010, 5'b00010);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("ls_br_c2", 5'b11110, 5'b11111);
      idle();
      cyc("ls_br_fl", 5'b11111, 5'b11111);
      cyc("ls_br_run", 5'b11000, 5'b11000);

      // reset mid-flush aborts
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("rf_br", 5'b11110, 5'b11110);
      idle();
      nreset = 1'b0;
      cyc("rf_rst", 5'b00110, 5'b00110);
`ifdef HAZARD_STATS_EN
      chk("stall_clr", sc_b, 16'd0);
      chk("flush_clr", fc_b, 16'd0);
`endif
      nreset = 1'b1;
      cyc("rf_run", 5'b11000, 5'b11000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
